gpio_debounce: RTL and testbench
================================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per debounce sample tick; legal range 2..2^20.
REQ-002 SHALL have parameter DB_TICKS, default 4, consecutive differing ticks needed to accept a new level; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port gpio_in  input  8  raw, asynchronous switch/button levels.
REQ-006 SHALL have port sw_state  output  8  debounced levels.
REQ-007 SHALL have port sw_rise  output  8  one-cycle pulse per bit on debounced 0->1.
REQ-008 SHALL have port sw_fall  output  8  one-cycle pulse per bit on debounced 1->0.
REQ-009 SHALL have port evt_valid  output  1  pending change event.
REQ-010 SHALL have port evt_bits  output  8  bits that changed since last accepted event.
REQ-011 SHALL have port evt_ack  input  1  consumer accepts event.
REQ-012 SHALL have port evt_overrun  output  1  sticky flag: change arrived while event pending and unacknowledged.

Function
REQ-013 SHALL pass each gpio_in bit through a 2-flop synchronizer; the second flop (sync) is the only consumer of gpio_in.
REQ-014 SHALL run a prescaler counting 0..TICK_DIV-1, wrapping to 0; tick is high for exactly the one cycle the counter equals TICK_DIV-1.
REQ-015 SHALL keep a per-bit stability counter, wide enough for DB_TICKS, updated only on tick cycles.
REQ-016 On tick, if sync bit equals sw_state bit, the bit's counter SHALL clear to 0.
REQ-017 On tick, if sync bit differs and counter < DB_TICKS-1, the counter SHALL increment.
REQ-018 On tick, if sync bit differs and counter = DB_TICKS-1, sw_state bit SHALL take the sync value at the next edge and the counter SHALL clear.
REQ-019 Latency: a clean gpio_in step SHALL reach sw_state after 2 sync cycles plus DB_TICKS ticks; a glitch shorter than DB_TICKS ticks SHALL never change sw_state.
REQ-020 sw_rise/sw_fall SHALL be registered alongside sw_state and assert in the same cycle the sw_state bit changes, for exactly one cycle.
REQ-021 change = sw_rise | sw_fall; all 8 bits are independent, and simultaneous bit changes SHALL be reported in one event.
REQ-022 If evt_valid=0 and change!=0: evt_valid<=1 and evt_bits<=change.
REQ-023 If evt_valid=1 and evt_ack=1: event consumed; evt_overrun<=0; evt_valid<=(change!=0); evt_bits<=change.
REQ-024 If evt_valid=1, evt_ack=0 and change!=0: evt_bits<=evt_bits|change and evt_overrun<=1; evt_valid stays 1.
REQ-025 If evt_valid=1, evt_ack=0 and change=0, evt_bits and evt_overrun SHALL hold.
REQ-026 evt_ack while evt_valid=0 SHALL be ignored.
REQ-027 evt_bits SHALL be 0 whenever evt_valid=0.

Reset
REQ-028 While rstn=1, all flops SHALL clear asynchronously: synchronizer, prescaler, stability counters, sw_state, sw_rise, sw_fall, evt_valid, evt_bits, evt_overrun = 0.
REQ-029 Reset mid-debounce SHALL discard partial counts; after release, any input already at 1 SHALL be re-qualified from scratch, then emit sw_rise and an event.
REQ-030 The first tick after reset release SHALL occur TICK_DIV cycles after release.

Verification (TICK_DIV=4, DB_TICKS=3)
REQ-031 Reset release with gpio_in=0x00 -> all outputs 0 indefinitely; tick every 4th cycle.
REQ-032 gpio_in 0x00->0x05 held -> sw_state=0x05 after 2 cycles plus 3 ticks; sw_rise=0x05 for one cycle; evt_valid=1, evt_bits=0x05.
REQ-033 gpio_in bit 3 pulsed high for 2 ticks, then low -> sw_state, sw_rise and evt_valid unchanged.
REQ-034 Event pending (evt_bits=0x01), no ack, bit 7 debounced to 1 -> evt_bits=0x81, evt_overrun=1; ack -> evt_valid=0, evt_overrun=0, evt_bits=0x00.
REQ-035 Ack in the same cycle as a new change on bit 2 -> evt_valid stays 1, evt_bits=0x04, evt_overrun=0.
REQ-036 rstn asserted while bit 0 counter=2 with gpio_in=0x01, then released -> sw_state stays 0 for 3 full ticks, then 0x01 with sw_rise=0x01.

Source files
------------

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - 8-bit GPIO synchronizer, tick-based debouncer and change-event latch
module gpio_debounce #(
   parameter int TICK_DIV = 50000,
   parameter int DB_TICKS = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] gpio_in,
   output logic [7:0] sw_state,
   output logic [7:0] sw_rise,
   output logic [7:0] sw_fall,
   output logic       evt_valid,
   output logic [7:0] evt_bits,
   input  logic       evt_ack,
   output logic       evt_overrun
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DB_TICKS - 1);

   logic [7:0]          sync1_q, sync1_d;
   logic [7:0]          sync2_q, sync2_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                tick;
   logic [7:0][CW-1:0]  cnt_q, cnt_d;
   logic [7:0]          sw_state_q, sw_state_d;
   logic [7:0]          sw_rise_q, sw_rise_d;
   logic [7:0]          sw_fall_q, sw_fall_d;
   logic [7:0]          change;
   logic                evt_valid_q, evt_valid_d;
   logic [7:0]          evt_bits_q, evt_bits_d;
   logic                evt_overrun_q, evt_overrun_d;

   // Two-stage synchronizer; only sync2_q is used by the rest of the block.
   always_comb begin
      sync1_d = gpio_in;
      sync2_d = sync1_q;
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // Prescaler: tick fires on the terminal count, so the first tick lands TICK_DIV cycles after reset.
   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Prescaler flop.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Per-bit stability counters: a level is accepted after DB_TICKS consecutive differing ticks.
   always_comb begin
      cnt_d      = cnt_q;
      sw_state_d = sw_state_q;
      sw_rise_d  = '0;
      sw_fall_d  = '0;
      if (tick) begin
         for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] == sw_state_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               cnt_d[i]      = '0;
               sw_state_d[i] = sync2_q[i];
               sw_rise_d[i]  = sync2_q[i];
               sw_fall_d[i]  = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Debounced state, edge pulses and stability counters.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         cnt_q      <= '0;
         sw_state_q <= '0;
         sw_rise_q  <= '0;
         sw_fall_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sw_state_q <= sw_state_d;
         sw_rise_q  <= sw_rise_d;
         sw_fall_q  <= sw_fall_d;
      end
   end

   // Event latch: accumulate changed bits until acked; flag changes that pile onto a pending event.
   always_comb begin
      change        = sw_rise_q | sw_fall_q;
      evt_valid_d   = evt_valid_q;
      evt_bits_d    = evt_bits_q;
      evt_overrun_d = evt_overrun_q;
      if (!evt_valid_q) begin
         if (change != '0) begin
            evt_valid_d = 1'b1;
            evt_bits_d  = change;
         end
      end else if (evt_ack) begin
         evt_overrun_d = 1'b0;
         evt_valid_d   = (change != '0);
         evt_bits_d    = change;
      end else if (change != '0) begin
         evt_bits_d    = evt_bits_q | change;
         evt_overrun_d = 1'b1;
      end
   end

   // Event flops.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         evt_valid_q   <= 1'b0;
         evt_bits_q    <= '0;
         evt_overrun_q <= 1'b0;
      end else begin
         evt_valid_q   <= evt_valid_d;
         evt_bits_q    <= evt_bits_d;
         evt_overrun_q <= evt_overrun_d;
      end
   end

   assign sw_state    = sw_state_q;
   assign sw_rise     = sw_rise_q;
   assign sw_fall     = sw_fall_q;
   assign evt_valid   = evt_valid_q;
   assign evt_bits    = evt_bits_q;
   assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - self-checking bench for gpio_debounce with a behavioural model
module tb_gpio_debounce;

   localparam int TD = 4;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic [7:0] gpio_in = 8'h00;
   logic       evt_ack = 1'b0;
   logic [7:0] sw_state, sw_rise, sw_fall, evt_bits;
   logic       evt_valid, evt_overrun;

   int total = 0;
   int bad = 0;

   gpio_debounce #(.TICK_DIV(TD), .DB_TICKS(DB)) dut (
      .clk(clk),
      .rstn(rstn),
      .gpio_in(gpio_in),
      .sw_state(sw_state),
      .sw_rise(sw_rise),
      .sw_fall(sw_fall),
      .evt_valid(evt_valid),
      .evt_bits(evt_bits),
      .evt_ack(evt_ack),
      .evt_overrun(evt_overrun)
   );

   always #5 clk = ~clk;

   // Behavioural model: inputs seen two edges late, ticks by edge count since release,
   // a level is accepted after DB consecutive disagreeing ticks.
   logic [7:0] m_state = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
   logic       m_valid = 1'b0, m_ovr = 1'b0;
   logic [7:0] m_bits = 8'h00;
   logic [7:0] d1 = 8'h00, d2 = 8'h00, seen, chg;
   int         run [8];
   int         ecount = 0;
   bit         m_tick;

   always @(posedge clk or posedge rstn) begin
      if (rstn) begin
         m_state = 0; m_rise = 0; m_fall = 0;
         m_valid = 0; m_ovr = 0; m_bits = 0;
         d1 = 0; d2 = 0; ecount = 0;
         for (int b = 0; b < 8; b++) run[b] = 0;
      end else begin
         seen = d2;
         d2 = d1;
         d1 = gpio_in;
         m_tick = ((ecount % TD) == TD - 1);
         ecount++;
         chg = m_rise | m_fall;
         if (!m_valid) begin
            if (chg != 0) begin m_valid = 1; m_bits = chg; end
         end else if (evt_ack) begin
            m_ovr = 0; m_valid = (chg != 0); m_bits = chg;
         end else if (chg != 0) begin
            m_bits = m_bits | chg; m_ovr = 1;
         end
         m_rise = 0;
         m_fall = 0;
         if (m_tick) begin
            for (int b = 0; b < 8; b++) begin
               if (seen[b] != m_state[b]) begin
                  run[b]++;
                  if (run[b] == DB) begin
                     m_state[b] = seen[b];
                     if (seen[b]) m_rise[b] = 1; else m_fall[b] = 1;
                     run[b] = 0;
                  end
               end else begin
                  run[b] = 0;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      total++;
      if (sw_state !== m_state || sw_rise !== m_rise || sw_fall !== m_fall ||
          evt_valid !== m_valid || evt_bits !== m_bits || evt_overrun !== m_ovr) begin
         bad++;
         $display("FAIL model @%0t: got st=%h r=%h f=%h v=%b b=%h o=%b want st=%h r=%h f=%h v=%b b=%h o=%b",
                  $time, sw_state, sw_rise, sw_fall, evt_valid, evt_bits, evt_overrun,
                  m_state, m_rise, m_fall, m_valid, m_bits, m_ovr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   bit got;

   initial begin
      // Reset release with idle inputs.
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle_state", {24'h0, sw_state}, 32'h00);
      chk("idle_evt", {31'h0, evt_valid}, 32'h0);
      #2 gpio_in = 8'h05;
      repeat (11) @(negedge clk);
      chk("step_not_yet", {24'h0, sw_state}, 32'h00);
      @(negedge clk);
      chk("step_state", {24'h0, sw_state}, 32'h05);
      chk("step_rise", {24'h0, sw_rise}, 32'h05);
      @(negedge clk);
      chk("step_rise_gone", {24'h0, sw_rise}, 32'h00);
      chk("step_evt_valid", {31'h0, evt_valid}, 32'h1);
      chk("step_evt_bits", {24'h0, evt_bits}, 32'h05);
      #2 evt_ack = 1'b1;
      @(negedge clk);
      chk("ack_valid", {31'h0, evt_valid}, 32'h0);
      chk("ack_bits", {24'h0, evt_bits}, 32'h00);
      #2 evt_ack = 1'b0;

      // Glitch on bit 3 lasting exactly two ticks.
      repeat (2) @(negedge clk);
      #2 gpio_in = 8'h0D;
      repeat (8) @(negedge clk);
      #2 gpio_in = 8'h05;
      repeat (20) @(negedge clk);
      chk("glitch_state", {24'h0, sw_state}, 32'h05);
      chk("glitch_evt", {31'h0, evt_valid}, 32'h0);

      // Overrun: pending fall on bit 0, then bit 7 rises without ack.
      #2 gpio_in = 8'h04;
      repeat (20) @(negedge clk);
      chk("pend_bits", {24'h0, evt_bits}, 32'h01);
      chk("pend_ovr", {31'h0, evt_overrun}, 32'h0);
      #2 gpio_in = 8'h84;
      repeat (20) @(negedge clk);
      chk("ovr_state", {24'h0, sw_state}, 32'h84);
      chk("ovr_bits", {24'h0, evt_bits}, 32'h81);
      chk("ovr_flag", {31'h0, evt_overrun}, 32'h1);
      #2 evt_ack = 1'b1;
      @(negedge clk);
      chk("ovr_ack_valid", {31'h0, evt_valid}, 32'h0);
      chk("ovr_ack_flag", {31'h0, evt_overrun}, 32'h0);
      chk("ovr_ack_bits", {24'h0, evt_bits}, 32'h00);
      #2 evt_ack = 1'b0;

      // Ack coinciding with a new change on bit 2.
      #2 gpio_in = 8'h85;
      repeat (20) @(negedge clk);
      chk("coinc_pend", {24'h0, evt_bits}, 32'h01);
      #2 gpio_in = 8'h81;
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         @(negedge clk);
         got = (sw_fall != 8'h00);
      end
      chk("coinc_wait", {31'h0, got}, 32'h1);
      chk("coinc_fall", {24'h0, sw_fall}, 32'h04);
      #2 evt_ack = 1'b1;
      @(negedge clk);
      chk("coinc_valid", {31'h0, evt_valid}, 32'h1);
      chk("coinc_bits", {24'h0, evt_bits}, 32'h04);
      chk("coinc_ovr", {31'h0, evt_overrun}, 32'h0);
      #2 evt_ack = 1'b0;
      @(negedge clk);
      #2 evt_ack = 1'b1;
      @(negedge clk);
      #2 evt_ack = 1'b0;

      // Reset mid-debounce: bit 0 counter at 2, then requalify from scratch.
      @(negedge clk);
      #2 begin rstn = 1'b1; gpio_in = 8'h00; end
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      repeat (8) @(negedge clk);
      #2 gpio_in = 8'h01;
      repeat (9) @(negedge clk);
      #2 rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_state", {24'h0, sw_state}, 32'h00);
      #2 rstn = 1'b0;
      for (int m = 1; m <= 13; m++) begin
         @(negedge clk);
         if (m == 4)  chk("rq_early", {24'h0, sw_state}, 32'h00);
         if (m == 11) chk("rq_late", {24'h0, sw_state}, 32'h00);
         if (m == 12) begin
            chk("rq_state", {24'h0, sw_state}, 32'h01);
            chk("rq_rise", {24'h0, sw_rise}, 32'h01);
         end
         if (m == 13) begin
            chk("rq_evt_valid", {31'h0, evt_valid}, 32'h1);
            chk("rq_evt_bits", {24'h0, evt_bits}, 32'h01);
         end
      end

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
